// File: rtl/frame_buf_mc.sv
// rtl/frame_buf_mc.sv - multi-channel double-buffered frame buffer controller on one Avalon-MM master
// Each channel is a 2-deep frame FIFO in DDR; a round-robin arbiter feeds a two-state bus FSM.
module frame_buf_mc #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 29,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned BASE_ADDR  = 2,
    parameter int unsigned BUF_SIZE   = 307200,
    parameter int unsigned CH_STRIDE  = 2 * BUF_SIZE,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ram_rdy,
    input  logic                         avl_ready,
    input  logic [NUM_CH-1:0]            wr_en,
    input  logic [NUM_CH-1:0]            rd_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    output logic                         avl_write_req,
    output logic                         avl_read_req,
    output logic [ADDR_WIDTH-1:0]        avl_addr,
    output logic [DATA_WIDTH-1:0]        avl_wdata,
    output logic [CH_W-1:0]              avl_ch,
    output logic [NUM_CH-1:0]            wr_ack,
    output logic [NUM_CH-1:0]            rd_ack,
    output logic [NUM_CH-1:0]            full,
    output logic [NUM_CH-1:0]            frame_wr_done,
    output logic [NUM_CH-1:0]            rd_done
);

    localparam int unsigned NREQ  = 2 * NUM_CH;
    localparam int unsigned REQ_W = $clog2(NREQ);
    localparam int unsigned OFF_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BUF_SIZE - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   do_grant, do_accept;

    // Requester r: channel r/2, even = writer, odd = reader
    logic [NREQ-1:0]              elig;
    logic [NUM_CH*ADDR_WIDTH-1:0] wr_addr_flat;
    logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr_flat;

    logic [REQ_W-1:0]      rr_ptr;
    logic [REQ_W-1:0]      gnt_next;
    logic                  sel_found;
    logic                  sel_rd;
    logic [CH_W-1:0]       sel_ch;
    logic [REQ_W-1:0]      sel_next;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam longint unsigned CH_BASE = 64'(BASE_ADDR) + 64'(g) * 64'(CH_STRIDE);

        logic             wr_slot, rd_slot;
        logic [OFF_W-1:0] wr_off, rd_off;
        logic [1:0]       slot_full;
        logic             wr_ack_q, rd_ack_q, wr_done_q, rd_done_q;
        logic             acc_wr, acc_rd;

        assign acc_wr = do_accept & avl_write_req & (avl_ch == CH_W'(g));
        assign acc_rd = do_accept & avl_read_req  & (avl_ch == CH_W'(g));

        assign elig[2*g]   = ~wr_en[g] & ram_rdy & ~slot_full[wr_slot];
        assign elig[2*g+1] = ~rd_en[g] & ram_rdy &  slot_full[rd_slot];

        assign wr_addr_flat[g*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(CH_BASE)
            + (wr_slot ? ADDR_WIDTH'(BUF_SIZE) : '0) + ADDR_WIDTH'(wr_off);
        assign rd_addr_flat[g*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(CH_BASE)
            + (rd_slot ? ADDR_WIDTH'(BUF_SIZE) : '0) + ADDR_WIDTH'(rd_off);

        assign full[g]          = &slot_full;
        assign wr_ack[g]        = wr_ack_q;
        assign rd_ack[g]        = rd_ack_q;
        assign frame_wr_done[g] = wr_done_q;
        assign rd_done[g]       = rd_done_q;

        // Only one transfer completes per cycle, so acc_wr and acc_rd never coincide
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_slot   <= 1'b0;
                rd_slot   <= 1'b0;
                wr_off    <= '0;
                rd_off    <= '0;
                slot_full <= 2'b00;
                wr_ack_q  <= 1'b0;
                rd_ack_q  <= 1'b0;
                wr_done_q <= 1'b0;
                rd_done_q <= 1'b0;
            end else begin
                wr_ack_q  <= acc_wr;
                rd_ack_q  <= acc_rd;
                wr_done_q <= acc_wr && (wr_off == OFF_LAST);
                rd_done_q <= acc_rd && (rd_off == OFF_LAST);
                if (acc_wr) begin
                    if (wr_off == OFF_LAST) begin
                        slot_full[wr_slot] <= 1'b1;
                        wr_slot            <= ~wr_slot;
                        wr_off             <= '0;
                    end else begin
                        wr_off <= wr_off + OFF_W'(1);
                    end
                end
                if (acc_rd) begin
                    if (rd_off == OFF_LAST) begin
                        slot_full[rd_slot] <= 1'b0;
                        rd_slot            <= ~rd_slot;
                        rd_off             <= '0;
                    end else begin
                        rd_off <= rd_off + OFF_W'(1);
                    end
                end
            end
        end
    end

    // First eligible requester at or after the round-robin pointer
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_rd    = 1'b0;
        sel_ch    = '0;
        sel_next  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!sel_found && elig[idx[REQ_W-1:0]]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(idx >> 1);
                sel_rd    = idx[0];
                sel_next  = (idx + 1 >= NREQ) ? '0 : REQ_W'(idx + 1);
            end
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (sel_ch == CH_W'(c)) begin
                sel_addr  = sel_rd ? rd_addr_flat[c*ADDR_WIDTH +: ADDR_WIDTH]
                                   : wr_addr_flat[c*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        do_grant  = 1'b0;
        do_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    do_grant = 1'b1;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (avl_ready) begin
                    do_accept = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus-side registers stay frozen while BUSY so the request is held until accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avl_write_req <= 1'b0;
            avl_read_req  <= 1'b0;
            avl_addr      <= '0;
            avl_wdata     <= '0;
            avl_ch        <= '0;
            rr_ptr        <= '0;
            gnt_next      <= '0;
        end else begin
            if (do_grant) begin
                avl_addr <= sel_addr;
                avl_ch   <= sel_ch;
                gnt_next <= sel_next;
                if (sel_rd) begin
                    avl_read_req <= 1'b1;
                end else begin
                    avl_write_req <= 1'b1;
                    avl_wdata     <= sel_wdata;
                end
            end
            if (do_accept) begin
                avl_write_req <= 1'b0;
                avl_read_req  <= 1'b0;
                rr_ptr        <= gnt_next;
            end
        end
    end

endmodule

// File: tb/tb_frame_buf_mc.sv
// tb/tb_frame_buf_mc.sv - directed and randomized checks of frame_buf_mc against a frame-count model
module tb_frame_buf_mc;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 29;
    localparam int unsigned NC = 2;
    localparam int unsigned BA = 2;
    localparam int unsigned BS = 4;
    localparam int unsigned CS = 2 * BS;
    localparam int unsigned NR = 2 * NC;

    logic              clk = 1'b0;
    logic              reset;
    logic              ram_rdy;
    logic              avl_ready;
    logic [NC-1:0]     wr_en;
    logic [NC-1:0]     rd_en;
    logic [NC*DW-1:0]  wr_data;
    logic              avl_write_req;
    logic              avl_read_req;
    logic [AW-1:0]     avl_addr;
    logic [DW-1:0]     avl_wdata;
    logic [0:0]        avl_ch;
    logic [NC-1:0]     wr_ack, rd_ack, full, frame_wr_done, rd_done;

    frame_buf_mc #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC),
        .BASE_ADDR(BA), .BUF_SIZE(BS), .CH_STRIDE(CS)
    ) dut (
        .clk(clk), .reset(reset), .ram_rdy(ram_rdy), .avl_ready(avl_ready),
        .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
        .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
        .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_ch(avl_ch),
        .wr_ack(wr_ack), .rd_ack(rd_ack), .full(full),
        .frame_wr_done(frame_wr_done), .rd_done(rd_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: per-channel word totals; frames held = completed writes - completed reads
    int unsigned   wc[NC];
    int unsigned   rc[NC];
    bit            m_busy, m_rd;
    int unsigned   m_ch, m_ptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [NC-1:0] m_wack, m_rack, m_wdone, m_rdone;

    function automatic int unsigned frames_held(int unsigned c);
        return wc[c] / BS - rc[c] / BS;
    endfunction

    function automatic logic [AW-1:0] word_addr(int unsigned c, int unsigned n);
        return AW'(BA + c * CS + ((n / BS) % 2) * BS + n % BS);
    endfunction

    function automatic bit can_go(int unsigned r);
        int unsigned c = r / 2;
        if (!ram_rdy) return 1'b0;
        if (r % 2 == 0) return !wr_en[c] && frames_held(c) < 2;
        return !rd_en[c] && frames_held(c) >= 1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            wc[c] = 0;
            rc[c] = 0;
        end
        m_busy = 1'b0; m_rd = 1'b0; m_ch = 0; m_ptr = 0;
        m_addr = '0; m_wdata = '0;
        m_wack = '0; m_rack = '0; m_wdone = '0; m_rdone = '0;
    endtask

    task automatic model_edge();
        m_wack = '0; m_rack = '0; m_wdone = '0; m_rdone = '0;
        if (m_busy) begin
            if (avl_ready) begin
                m_busy = 1'b0;
                if (m_rd) begin
                    rc[m_ch]++;
                    m_rack[m_ch] = 1'b1;
                    if (rc[m_ch] % BS == 0) m_rdone[m_ch] = 1'b1;
                end else begin
                    wc[m_ch]++;
                    m_wack[m_ch] = 1'b1;
                    if (wc[m_ch] % BS == 0) m_wdone[m_ch] = 1'b1;
                end
                m_ptr = (2 * m_ch + (m_rd ? 1 : 0) + 1) % NR;
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                int unsigned r = (m_ptr + k) % NR;
                if (can_go(r)) begin
                    m_busy = 1'b1;
                    m_ch   = r / 2;
                    m_rd   = (r % 2) == 1;
                    if (m_rd) begin
                        m_addr = word_addr(m_ch, rc[m_ch]);
                    end else begin
                        m_addr  = word_addr(m_ch, wc[m_ch]);
                        m_wdata = wr_data[m_ch*DW +: DW];
                    end
                    break;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NC-1:0] ef;
        for (int c = 0; c < NC; c++) ef[c] = frames_held(c) == 2;
        chk("write_req", 64'(avl_write_req), 64'(m_busy && !m_rd));
        chk("read_req", 64'(avl_read_req), 64'(m_busy && m_rd));
        if (m_busy) begin
            chk("addr", 64'(avl_addr), 64'(m_addr));
            chk("ch", 64'(avl_ch), 64'(m_ch));
            if (!m_rd) chk("wdata", 64'(avl_wdata), 64'(m_wdata));
        end
        chk("wr_ack", 64'(wr_ack), 64'(m_wack));
        chk("rd_ack", 64'(rd_ack), 64'(m_rack));
        chk("frame_wr_done", 64'(frame_wr_done), 64'(m_wdone));
        chk("rd_done", 64'(rd_done), 64'(m_rdone));
        chk("full", 64'(full), 64'(ef));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int          n_cnt;
        logic [DW-1:0] d_drv;

        reset = 1'b0; ram_rdy = 1'b1; avl_ready = 1'b1;
        wr_en = '1; rd_en = '1; wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_addr", 64'(avl_addr), 64'd0);
        chk("rst_wdata", 64'(avl_wdata), 64'd0);
        chk("rst_ch", 64'(avl_ch), 64'd0);
        reset = 1'b1;

        // ch0 writes two frames then must stall on full
        wr_en = 2'b10; n_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            wr_data = {$urandom, $urandom};
            cyc();
            if (wr_ack[0]) n_cnt++;
            if (i == 0) chk("a_first_addr", 64'(avl_addr), 64'd2);
        end
        chk("a_write_count", 64'(n_cnt), 64'd8);
        chk("a_full0", 64'(full[0]), 64'd1);

        // reader drains; writer resumes at slot 0
        rd_en = 2'b10; n_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            wr_data = {$urandom, $urandom};
            cyc();
            if (rd_done[0]) n_cnt++;
            if (i == 7) chk("b_full0_clear", 64'(full[0]), 64'd0);
            if (i == 8) chk("b_resume_addr", 64'(avl_addr), 64'd2);
        end
        chk("b_rd_done_count", 64'(n_cnt), 64'd2);
        rd_en = '1; wr_en = '1;
        repeat (2) cyc();

        // ch1 write held across three stalled cycles
        wr_en = 2'b01; avl_ready = 1'b0;
        wr_data = {$urandom, $urandom};
        d_drv = wr_data[DW +: DW];
        cyc();
        chk("d_grant_addr", 64'(avl_addr), 64'd10);
        n_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            wr_data = {$urandom, $urandom};
            cyc();
            if (wr_ack[1]) n_cnt++;
            chk("d_stall_req", 64'(avl_write_req), 64'd1);
            chk("d_stall_addr", 64'(avl_addr), 64'd10);
            chk("d_stall_wdata", 64'(avl_wdata), 64'(d_drv));
        end
        chk("d_no_early_ack", 64'(n_cnt), 64'd0);
        avl_ready = 1'b1;
        cyc();
        chk("d_single_ack", 64'(wr_ack), 64'b10);
        cyc();
        chk("d_no_skip_addr", 64'(avl_addr), 64'd11);
        cyc();

        // both channels writing: arbiter alternates
        wr_en = 2'b00;
        for (int i = 0; i < 16; i++) begin
            wr_data = {$urandom, $urandom};
            cyc();
        end

        // ram_rdy low: in-flight write completes, nothing new granted
        avl_ready = 1'b0;
        cyc();
        ram_rdy = 1'b0; avl_ready = 1'b1;
        cyc();
        chk("e_inflight_ack", 64'(|wr_ack), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("e_no_grant", 64'(avl_write_req | avl_read_req), 64'd0);
        end
        ram_rdy = 1'b1;

        for (int i = 0; i < 600; i++) begin
            wr_en     = NC'($urandom);
            rd_en     = NC'($urandom);
            ram_rdy   = ($urandom % 8) != 0;
            avl_ready = ($urandom % 3) != 0;
            wr_data   = {$urandom, $urandom};
            cyc();
        end

        // reset while BUSY
        wr_en = '0; rd_en = '0; ram_rdy = 1'b1; avl_ready = 1'b0;
        repeat (2) cyc();
        chk("g_busy_before_reset", 64'(avl_write_req | avl_read_req), 64'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("g_rst_req", 64'(avl_write_req | avl_read_req), 64'd0);
        chk("g_rst_addr", 64'(avl_addr), 64'd0);
        chk("g_rst_wdata", 64'(avl_wdata), 64'd0);
        chk("g_rst_ch", 64'(avl_ch), 64'd0);
        chk("g_rst_full", 64'(full), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; avl_ready = 1'b1;
        wr_en = '1; rd_en = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("g_empty_read_blocked", 64'(avl_read_req), 64'd0);
        end
        rd_en = '1; wr_en = 2'b10;
        cyc();
        chk("g_restart_req", 64'(avl_write_req), 64'd1);
        chk("g_restart_addr", 64'(avl_addr), 64'd2);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
